// File: rtl/char_tx.sv
// char_tx: serial character transmitter.
// Sends a 7-bit character as start(0), data LSB first, optional even parity,
// stop(1). Every bit lasts CLKS_PER_BIT cycles of clk_2.
//
// Ports:
//   clk_2    in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   char_in  in   [6:0] character, captured when a send is accepted
//   send     in   transmit request, honoured only in IDLE
//   txd      out  registered serial line, idles high
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse on the first IDLE cycle after a stop bit
//
// state  | meaning
// IDLE   | line high, waiting for send
// START  | driving the start bit (0)
// DATA   | driving data bits 0..6, LSB first
// PARITY | driving the XOR of the captured data bits
// STOP   | driving the stop bit (1)
module char_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [6:0] char_in,
  input  logic       send,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;
  logic        bit_end;

  assign bit_end = (cnt_q == 16'd0);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shreg_q <= 7'd0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;

    // Bit timer: counts down and reloads on every bit boundary while framing.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? RELOAD : cnt_q - 16'd1;
    end

    // txd_d is the value the line takes for the upcoming bit, so txd stays
    // a pure register output.
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (send) begin
          state_d = START;
          txd_d   = 1'b0;
          cnt_d   = RELOAD;
          shreg_d = char_in;
          par_d   = ^char_in;
          idx_d   = 3'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[6:1]};
          if (idx_q == 3'd6) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = shreg_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          txd_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign txd  = txd_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: doc/char_tx.md
CHAR_TX -- requirements
Module: char_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk_2 cycles per serial bit; legal values are 2 to 65535.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits, 0 omits it.
REQ-003 SHALL have port clk_2, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port char_in, input, 7 bits: character to transmit.
REQ-006 SHALL have port send, input, 1 bit: request to transmit char_in.
REQ-007 SHALL have port txd, output, 1 bit: serial line; idle level is 1.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-010 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-011 Frame format SHALL be, in order:
  - start bit 0;
  - char_in[0] through char_in[6], LSB first;
  - parity bit (only when PARITY_EN=1), equal to the XOR of the 7 data bits;
  - stop bit 1.
REQ-012 Each bit SHALL hold on txd for exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads at every bit boundary.
REQ-013 In IDLE, a cycle with send=1 SHALL capture char_in into an internal shift register and move to START; on the next cycle txd=0 and busy=1.
REQ-014 The captured character SHALL be used for the whole frame; changes on char_in after acceptance SHALL NOT affect the frame.
REQ-015 While busy=1, send SHALL be ignored; there is no queueing.
REQ-016 DATA SHALL use a 3-bit bit index counting 0 to 6 and SHALL shift the register right once per bit period; after index 6 it moves to PARITY, or to STOP when PARITY_EN=0.
REQ-017 When the final stop-bit period completes, the block SHALL return to IDLE, with busy=0 and done=1 for exactly that first IDLE cycle.
REQ-018 A send=1 in the same cycle as done=1 SHALL be accepted, giving back-to-back frames with no idle gap beyond the stop bit.
REQ-019 txd SHALL come from a register, with no combinational path from any input to txd.
REQ-020 Total frame duration SHALL be (9+PARITY_EN)*CLKS_PER_BIT cycles, measured from the first txd=0 cycle to the cycle done=1.
REQ-021 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for a clock edge, force:
  - state IDLE;
  - txd=1, busy=0, done=0;
  - bit counter, bit index and shift register to 0.
REQ-023 Reset during a frame SHALL abort it without emitting a stop bit or done.
REQ-024 The first send after reset is released SHALL start a complete new frame.

Verification
REQ-025 The bench SHALL use CLKS_PER_BIT=4 and PARITY_EN=1 unless stated otherwise, and SHALL cover these scenarios:
  - send=1 for one cycle with char_in=7'h41 -> txd bits (4 cycles each) 0,1,0,0,0,0,0,1,0,1; done pulses once, 40 cycles after the start edge.
  - char_in=7'h07 -> parity bit 1; the sampled frame decodes back to 7'h07.
  - PARITY_EN=0, char_in=7'h7F -> 9 bit periods (36 cycles): start 0, seven 1s, stop 1.
  - send held high continuously with char_in=7'h41 then 7'h2A -> two frames back-to-back; txd never returns idle between the stop bit and the next start; send pulses during busy are ignored.
  - reset asserted mid-DATA -> txd=1 and busy=0 immediately, no done pulse; the next send produces a full correct frame.
  - char_in changed every cycle while busy -> the transmitted bits match the value captured at acceptance.
